uart_tx_drain: RTL and testbench

//  UART transmitter that drains bytes from the TX FIFO (standard, non-FWFT read mode) and serialises them onto o_Tx.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_cnt.sv | 42 ++++
 rtl/uart_tx_drain.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_drain.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity modes and baud presets
// used by the transmit drain and the future receiver.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_LOAD   = 3'd2;
  localparam state_t ST_START  = 3'd3;
  localparam state_t ST_DATA   = 3'd4;
  localparam state_t ST_PARITY = 3'd5;
  localparam state_t ST_STOP   = 3'd6;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

  localparam int BAUD_115200_100MHZ = 868;

  // Parity bit sent after data bit 7; NONE never reaches the line.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
    if (mode == PARITY_ODD) begin
      parity_bit = ~(^data);
    end else begin
      parity_bit = ^data;
    end
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, ticks on the last cycle of each
// bit and restarts from zero whenever the owner FSM changes state.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Clr,
  output logic o_Tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear on request, wrap at the bit boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (i_Clr) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Counter register.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_Tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter draining a standard (non-FWFT) TX FIFO; prefetches the next
// byte during the stop bit so consecutive frames leave with no idle gap.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int    CLKS_PER_BIT = BAUD_115200_100MHZ,
  parameter string PARITY       = "NONE",
  parameter int    STOP_BITS    = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Enable,
  input  logic       i_FifoEmpty,
  output logic       o_FifoRdEn,
  input  logic [7:0] i_FifoRdData,
  output logic       o_Tx,
  output logic       o_Busy,
  output logic       o_FrameDone
);

  localparam logic [1:0] PAR_MODE = (PARITY == "EVEN") ? PARITY_EVEN :
                                    (PARITY == "ODD")  ? PARITY_ODD  : PARITY_NONE;
  localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  state_t     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [7:0] hold_q, hold_d;
  logic       pending_q, pending_d;
  logic       pf_rd_q, pf_rd_d;
  logic       stop_first_q, stop_first_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       stop_idx_q, stop_idx_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;

  logic tick_s;
  logic rd_idle_s;
  logic rd_stop_s;
  logic stop_last_s;

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Clr   (state_d != state_q),
    .o_Tick  (tick_s)
  );

  // Reads are gated by reset and the empty flag so the FIFO can never underflow.
  assign rd_idle_s   = i_Rst_n & (state_q == ST_IDLE) & i_Enable & ~i_FifoEmpty;
  assign rd_stop_s   = i_Rst_n & (state_q == ST_STOP) & stop_first_q & i_Enable & ~i_FifoEmpty;
  assign stop_last_s = (state_q == ST_STOP) & tick_s & (stop_idx_q == LAST_STOP);

  assign o_FifoRdEn  = rd_idle_s | rd_stop_s;
  assign o_FrameDone = stop_last_s;
  assign o_Tx        = tx_q;
  assign o_Busy      = busy_q;

  // Frame sequencing, byte capture and stop-bit prefetch bookkeeping.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    hold_d    = hold_q;
    pending_d = pending_q;
    bit_idx_d = bit_idx_q;
    stop_idx_d = stop_idx_q;
    pf_rd_d   = rd_stop_s;
    case (state_q)
      ST_IDLE: begin
        if (rd_idle_s) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      // The FIFO output register is valid the cycle after the read; take it
      // now so the start bit follows on the next cycle.
      ST_FETCH, ST_LOAD: begin
        data_d  = i_FifoRdData;
        state_d = ST_START;
      end
      ST_START: begin
        if (tick_s) begin
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s && (bit_idx_q == 3'd7)) begin
          bit_idx_d  = 3'd0;
          stop_idx_d = 1'b0;
          state_d    = (PAR_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end else if (tick_s) begin
          bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          bit_idx_d = bit_idx_q;
        end
      end
      ST_PARITY: begin
        if (tick_s) begin
          stop_idx_d = 1'b0;
          state_d    = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (stop_last_s) begin
          stop_idx_d = 1'b0;
          if (pending_q) begin
            data_d    = hold_q;
            pending_d = 1'b0;
            state_d   = ST_START;
          end else if (pf_rd_q) begin
            // Prefetch landed on the final stop cycle (shortest bit period).
            data_d  = i_FifoRdData;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (tick_s) begin
            stop_idx_d = stop_idx_q + 1'b1;
          end else begin
            stop_idx_d = stop_idx_q;
          end
          if (pf_rd_q) begin
            hold_d    = i_FifoRdData;
            pending_d = 1'b1;
          end else begin
            hold_d = hold_q;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

  // Line level and busy flag decoded from the next state so both come out of flops.
  always_comb begin
    stop_first_d = (state_d == ST_STOP) && (state_q != ST_STOP);
    busy_d       = (state_d != ST_IDLE);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_d[bit_idx_d];
      ST_PARITY: tx_d = parity_bit(data_d, PAR_MODE);
      default:   tx_d = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame and drops fetched or held bytes.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q      <= ST_IDLE;
      data_q       <= 8'h00;
      hold_q       <= 8'h00;
      pending_q    <= 1'b0;
      pf_rd_q      <= 1'b0;
      stop_first_q <= 1'b0;
      bit_idx_q    <= 3'd0;
      stop_idx_q   <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      hold_q       <= hold_d;
      pending_q    <= pending_d;
      pf_rd_q      <= pf_rd_d;
      stop_first_q <= stop_first_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: three parameter sets share one non-FWFT FIFO model,
// with a byte scoreboard checked cycle by cycle against the serial line.
module tb_uart_tx_drain;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] sel = 2'd0;

  logic [2:0] en_w, empty_w, rd_w, tx_w, busy_w, done_w;
  logic       rd_s, tx_s, busy_s, done_s;

  logic [7:0] fifo_q[$];
  logic [7:0] stage_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_empty = 1'b1;
  int         rd_pulses = 0;
  int         rd_underflow = 0;
  int         cyc = 0;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign en_w[0] = en & (sel == 2'd0);
  assign en_w[1] = en & (sel == 2'd1);
  assign en_w[2] = en & (sel == 2'd2);
  assign empty_w[0] = (sel == 2'd0) ? fifo_empty : 1'b1;
  assign empty_w[1] = (sel == 2'd1) ? fifo_empty : 1'b1;
  assign empty_w[2] = (sel == 2'd2) ? fifo_empty : 1'b1;
  assign rd_s   = rd_w[sel];
  assign tx_s   = tx_w[sel];
  assign busy_s = busy_w[sel];
  assign done_s = done_w[sel];

  uart_tx_drain #(.CLKS_PER_BIT(CPB), .PARITY("NONE"), .STOP_BITS(1)) dut_8n1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(en_w[0]), .i_FifoEmpty(empty_w[0]),
    .o_FifoRdEn(rd_w[0]), .i_FifoRdData(fifo_rdata), .o_Tx(tx_w[0]),
    .o_Busy(busy_w[0]), .o_FrameDone(done_w[0]));

  uart_tx_drain #(.CLKS_PER_BIT(CPB), .PARITY("EVEN"), .STOP_BITS(1)) dut_8e1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(en_w[1]), .i_FifoEmpty(empty_w[1]),
    .o_FifoRdEn(rd_w[1]), .i_FifoRdData(fifo_rdata), .o_Tx(tx_w[1]),
    .o_Busy(busy_w[1]), .o_FrameDone(done_w[1]));

  uart_tx_drain #(.CLKS_PER_BIT(CPB), .PARITY("ODD"), .STOP_BITS(2)) dut_8o2 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(en_w[2]), .i_FifoEmpty(empty_w[2]),
    .o_FifoRdEn(rd_w[2]), .i_FifoRdData(fifo_rdata), .o_Tx(tx_w[2]),
    .o_Busy(busy_w[2]), .o_FrameDone(done_w[2]));

  // Non-FWFT FIFO: data appears the cycle after a read; pushes land on the next edge.
  always @(posedge clk) begin
    if (rd_s) begin
      rd_pulses <= rd_pulses + 1;
      if (fifo_q.size() == 0) rd_underflow <= rd_underflow + 1;
      else fifo_rdata <= fifo_q.pop_front();
    end
    while (stage_q.size() > 0) fifo_q.push_back(stage_q.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
    cyc <= cyc + 1;
  end

  task automatic push_byte(input logic [7:0] b);
    stage_q.push_back(b);
    exp_q.push_back(b);
  endtask

  // Waits for a start bit, pops the expected byte and checks every cycle of the frame.
  task automatic check_frame(input string name, output int start_cyc);
    logic [7:0]  b;
    logic [11:0] bits;
    int n, nbits, per;
    n = 0;
    while (tx_s !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    start_cyc = cyc;
    checks++;
    if (tx_s !== 1'b0 || exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s start: tx=%b queued=%0d, required tx=0 with a queued byte", name, tx_s, exp_q.size());
      return;
    end
    b = exp_q.pop_front();
    bits = 12'hFFF;
    bits[0] = 1'b0;
    bits[8:1] = b;
    nbits = 10;
    if (sel == 2'd1) begin
      bits[9] = ^b;
      nbits = 11;
    end
    if (sel == 2'd2) begin
      bits[9] = ~^b;
      nbits = 12;
    end
    per = nbits * CPB;
    for (int c = 0; c < per; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (tx_s !== bits[c / CPB]) begin
        fails++;
        $display("FAIL %s tx byte=%h cycle %0d: got %b expected %b", name, b, c, tx_s, bits[c / CPB]);
      end
      checks++;
      if (done_s !== ((c == per - 1) ? 1'b1 : 1'b0)) begin
        fails++;
        $display("FAIL %s frame_done cycle %0d: got %b expected %b", name, c, done_s, (c == per - 1));
      end
      checks++;
      if (busy_s !== 1'b1) begin
        fails++;
        $display("FAIL %s busy cycle %0d: got %b expected 1", name, c, busy_s);
      end
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (tx_s !== 1'b1 || busy_s !== 1'b0 || rd_s !== 1'b0) begin
      fails++;
      $display("FAIL %s idle: tx=%b busy=%b rd=%b, expected 1/0/0", name, tx_s, busy_s, rd_s);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_w !== 3'b111 || rd_w !== 3'b000 || busy_w !== 3'b000 || done_w !== 3'b000) begin
      fails++;
      $display("FAIL reset outputs: tx=%b rd=%b busy=%b done=%b, expected 111/000/000/000", tx_w, rd_w, busy_w, done_w);
    end
    rst_n = 1'b1;
    en = 1'b1;
    @(negedge clk);
    check_idle("post_reset");
  endtask

  task automatic test_single;
    int n, s, r0;
    r0 = rd_pulses;
    push_byte(8'hA5);
    n = 0;
    while (rd_s !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rd_s !== 1'b1) begin
      fails++;
      $display("FAIL single rd_en: got %b expected 1", rd_s);
    end
    @(negedge clk);
    checks++;
    if (rd_s !== 1'b0 || tx_s !== 1'b1) begin
      fails++;
      $display("FAIL single fetch: rd=%b tx=%b, expected 0/1", rd_s, tx_s);
    end
    @(negedge clk);
    checks++;
    if (tx_s !== 1'b0) begin
      fails++;
      $display("FAIL single latency: tx=%b two cycles after rd, expected 0", tx_s);
    end
    check_frame("single_a5", s);
    @(negedge clk);
    check_idle("single_end");
    checks++;
    if (rd_pulses - r0 !== 1) begin
      fails++;
      $display("FAIL single rd_count: got %0d expected 1", rd_pulses - r0);
    end
  endtask

  task automatic test_back_to_back;
    int s1, s2, r0;
    r0 = rd_pulses;
    push_byte(8'h00);
    push_byte(8'hFF);
    check_frame("b2b_first", s1);
    check_frame("b2b_second", s2);
    checks++;
    if (s2 - s1 !== 40) begin
      fails++;
      $display("FAIL b2b spacing: got %0d cycles expected 40", s2 - s1);
    end
    @(negedge clk);
    check_idle("b2b_end");
    checks++;
    if (rd_pulses - r0 !== 2) begin
      fails++;
      $display("FAIL b2b rd_count: got %0d expected 2", rd_pulses - r0);
    end
  endtask

  task automatic test_parity_stop;
    int s;
    sel = 2'd1;
    @(negedge clk);
    push_byte(8'h07);
    check_frame("even_07", s);
    @(negedge clk);
    check_idle("even_end");
    sel = 2'd2;
    @(negedge clk);
    push_byte(8'h07);
    check_frame("odd_2stop_07", s);
    @(negedge clk);
    check_idle("odd_end");
    sel = 2'd0;
    @(negedge clk);
  endtask

  task automatic test_empty_idle;
    int s;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check_idle("empty_wait");
    end
    push_byte(8'h3C);
    check_frame("after_empty_3c", s);
  endtask

  task automatic test_reset_midframe;
    int n, s;
    logic [7:0] dropped;
    push_byte(8'h5A);
    push_byte(8'h11);
    n = 0;
    while (tx_s !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (17) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("reset_abort");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (rd_s !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold rd cycle %0d: got %b expected 0", i, rd_s);
      end
    end
    dropped = exp_q.pop_front();
    rst_n = 1'b1;
    check_frame("after_reset_11", s);
    @(negedge clk);
    check_idle("after_reset_end");
  endtask

  task automatic test_enable_drop;
    int n, s, r0;
    r0 = rd_pulses;
    push_byte(8'hC3);
    push_byte(8'h81);
    push_byte(8'h7E);
    n = 0;
    while (tx_s !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    en = 1'b0;
    check_frame("enable_drop_c3", s);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check_idle("enable_drop_idle");
    end
    checks++;
    if (rd_pulses - r0 !== 1) begin
      fails++;
      $display("FAIL enable_drop rd_count: got %0d expected 1", rd_pulses - r0);
    end
    checks++;
    if (fifo_q.size() + stage_q.size() !== 2) begin
      fails++;
      $display("FAIL enable_drop fifo_level: got %0d expected 2", fifo_q.size() + stage_q.size());
    end
    checks++;
    if (rd_underflow !== 0) begin
      fails++;
      $display("FAIL underflow: got %0d reads of an empty FIFO expected 0", rd_underflow);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_parity_stop;
    test_empty_idle;
    test_reset_midframe;
    test_enable_drop;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
